blk_mem_arbiter: RTL and testbench
==================================

BLK_MEM_ARBITER -- requirements
Module: blk_mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; BLK_W, default 256, cache-block width; TIMEOUT_CYC, default 64, watchdog limit in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning), in this order:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-side block-read request (iBlkRead).
- i_addr  in  ADDR_W  instruction block address.
- i_rdata  out  BLK_W  block returned to the instruction side.
- i_done  out  1  one-cycle completion pulse to the instruction side.
- d_req  in  1  data-side block request (dBlkRead or dBlkWrite).
- d_we  in  1  data-side request is a write when 1.
- d_addr  in  ADDR_W  data block address.
- d_wdata  in  BLK_W  data write block.
- d_rdata  out  BLK_W  block returned to the data side.
- d_done  out  1  one-cycle completion pulse to the data side.
- m_req  out  1  memory transaction request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  BLK_W  memory write block.
- m_rdata  in  BLK_W  memory read block.
- m_ack  in  1  memory completion, valid while m_req is high.
- busy  out  1  arbiter is not in IDLE.
- err  out  1  sticky timeout flag.

Function
REQ-003 SHALL be a single memory-port arbiter with states IDLE, GNT_I, GNT_D and RESP, all outputs registered.
REQ-004 IDLE: if only one req is high, SHALL grant it; if both are high, SHALL grant the side not granted last (round robin via last_gnt bit, reset value = I, so D wins the first tie).
REQ-005 On the grant edge SHALL latch addr, we and wdata of the winner; I-side grants force m_we=0.
REQ-006 m_req SHALL rise in the cycle after the request is sampled and stay high until m_ack is sampled high in GNT_I or GNT_D.
REQ-007 On sampling m_ack SHALL capture m_rdata into the granted side's rdata register (not for writes), drop m_req and enter RESP.
REQ-008 In RESP SHALL pulse exactly one of i_done or d_done for one cycle, then return to IDLE.
REQ-009 Minimum latency: req sampled in cycle N, m_req high in N+1, m_ack in N+1 -> done high in N+2, IDLE in N+3.
REQ-010 Requester SHALL hold req, addr, we and wdata stable until its done pulse; a req sampled high in IDLE after done is a new request.
REQ-011 m_ack SHALL be ignored in IDLE and RESP; the losing req SHALL stay pending and be served next.
REQ-012 rdata registers SHALL hold their value until the next read completion for that side.
REQ-013 busy SHALL be 1 in GNT_I, GNT_D and RESP.

Reset
REQ-014 RESET low SHALL force IDLE asynchronously: last_gnt=I; busy, err, m_req, m_we, i_done and d_done all 0; m_addr, m_wdata, i_rdata and d_rdata all zero.
REQ-015 Reset mid-transaction SHALL abandon the transaction with no done pulse.

Configuration
REQ-016 With ARB_TIMEOUT_EN defined, SHALL count cycles in GNT_I/GNT_D. On reaching TIMEOUT_CYC without m_ack it SHALL drop m_req, set err (sticky until reset), enter RESP and pulse done with rdata unchanged.
REQ-017 Without ARB_TIMEOUT_EN, SHALL contain no counter, tie err to 0 and wait indefinitely for m_ack.

Structure
REQ-018 SHALL take the state enum, ADDR_W/BLK_W/TIMEOUT_CYC defaults and the grant-side encoding from shared package blk_arb_pkg.
REQ-019 SHALL place the round-robin pick (two reqs plus last_gnt -> winner) in combinational sub-module blk_arb_rr.

Verification
REQ-020 Bench SHALL cover:
- i_req alone, i_addr=0x100, m_ack at N+1 -> m_req at N+1 with m_we=0, i_done at N+2, i_rdata=m_rdata.
- d_req with d_we=1, d_addr=0x200, m_ack after 5 cycles -> m_we=1, m_wdata=d_wdata, d_done 1 cycle after ack, d_rdata unchanged.
- i_req and d_req rising together from reset -> D served first, then I; repeated tie -> I then D alternation.
- RESET low while m_req high in GNT_D -> m_req=0 and busy=0 immediately, no d_done, IDLE after release.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8, m_ack never asserted -> m_req drops after 8 cycles, err=1, done pulse; err stays 1 until reset.
- m_ack high in IDLE -> no state change, no done pulse.

Source files
------------

// File: rtl/blk_arb_pkg.sv
// Shared definitions for the block-memory arbiter.
//   - default widths and watchdog limit
//   - arbiter state enum
//   - grant-side encoding used for the round-robin history bit
package blk_arb_pkg;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_BLK_W       = 256;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

endpackage

// File: rtl/blk_arb_rr.sv
// Round-robin pick between the instruction and data requesters.
// Ports:
//   i_req, d_req - pending requests
//   last_gnt     - side granted most recently
//   valid_c      - at least one request pending (combinational)
//   side_c       - winning side (combinational)
module blk_arb_rr
    import blk_arb_pkg::*;
(
    input  logic  i_req,
    input  logic  d_req,
    input  side_e last_gnt,
    output logic  valid_c,
    output side_e side_c
);

    // On a tie the side that did not win last time goes next.
    always_comb begin
        valid_c = i_req | d_req;
        side_c  = SIDE_I;
        if (i_req && d_req) begin
            side_c = (last_gnt == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (d_req) begin
            side_c = SIDE_D;
        end
    end

endmodule

// File: rtl/blk_mem_arbiter.sv
// Arbitrates instruction-side block reads and data-side block reads/writes
// onto a single memory port. One transaction at a time: grant, wait for
// m_ack, one-cycle done pulse to the winner, back to idle.
// Ports:
//   CLK, RESET (async, active low)
//   i_req/i_addr -> i_rdata/i_done     instruction side
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done   data side
//   m_req/m_we/m_addr/m_wdata, m_rdata/m_ack       memory port
//   busy (not idle), err (sticky watchdog timeout)
// Build option: define ARB_TIMEOUT_EN to enable the TIMEOUT_CYC watchdog;
// without it err is tied low and the arbiter waits for m_ack forever.
module blk_mem_arbiter
    import blk_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned BLK_W       = DEF_BLK_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [BLK_W-1:0]  i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic [BLK_W-1:0]  d_rdata,
    output logic              d_done,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BLK_W-1:0]  m_wdata,
    input  logic [BLK_W-1:0]  m_rdata,
    input  logic              m_ack,
    output logic              busy,
    output logic              err
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_e state_q;
    state_e state_d;
    side_e  last_gnt;
    side_e  side_c;
    logic   valid_c;
    logic   grant_c;
    logic   ack_c;
    logic   to_hit_c;

    blk_arb_rr u_rr (
        .i_req   (i_req),
        .d_req   (d_req),
        .last_gnt(last_gnt),
        .valid_c (valid_c),
        .side_c  (side_c)
    );

    // Next-state decode; m_ack is only honoured while a grant is active.
    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        ack_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    grant_c = 1'b1;
                    state_d = (side_c == SIDE_D) ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ack) begin
                    ack_c   = 1'b1;
                    state_d = RESP;
                end else if (to_hit_c) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State plus registered outputs, all derived from the next state.
    // last_gnt doubles as the side owning the current transaction.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            last_gnt <= SIDE_I;
            busy     <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            m_req   <= (state_d == GNT_I) || (state_d == GNT_D);
            i_done  <= (state_d == RESP) && (last_gnt == SIDE_I);
            d_done  <= (state_d == RESP) && (last_gnt == SIDE_D);

            if (grant_c) begin
                last_gnt <= side_c;
                if (side_c == SIDE_D) begin
                    m_addr  <= d_addr;
                    m_we    <= d_we;
                    m_wdata <= d_wdata;
                end else begin
                    m_addr <= i_addr;
                    m_we   <= 1'b0;
                end
            end

            if (state_d == RESP) begin
                m_we <= 1'b0;
            end

            // m_we still describes the completing transaction here.
            if (ack_c) begin
                if (last_gnt == SIDE_I) begin
                    i_rdata <= m_rdata;
                end else if (!m_we) begin
                    d_rdata <= m_rdata;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic             in_gnt_c;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign in_gnt_c = (state_q == GNT_I) || (state_q == GNT_D);
    // Fires in the last of TIMEOUT_CYC granted cycles.
    assign to_hit_c = in_gnt_c && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog counter, restarted on each grant; err is sticky.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant_c) begin
                cnt_q <= '0;
            end else if (in_gnt_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (to_hit_c && !m_ack) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign to_hit_c = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Testbench for blk_mem_arbiter: transaction-level model with per-cycle
// compare, plus directed scenarios with hand-computed expectations.
// Timeout scenario is built when ARB_TIMEOUT_EN is defined.
module tb_blk_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 256;
    localparam int unsigned TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [BW-1:0] i_rdata;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [BW-1:0] d_wdata = '0;
    logic [BW-1:0] d_rdata;
    logic          d_done;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata;
    logic [BW-1:0] m_rdata = '0;
    logic          m_ack = 1'b0;
    logic          busy;
    logic          err;

    always #5 CLK = ~CLK;

    blk_mem_arbiter #(.ADDR_W(AW), .BLK_W(BW), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] pat(input logic [AW-1:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    // Memory responder: ack in the ack_lat-th cycle of m_req (0 = never).
    int ack_lat = 1;
    bit idle_ack = 1'b0;
    int rq_cnt = 0;
    always @(negedge CLK) begin
        m_rdata = pat(m_addr);
        if (m_req) begin
            rq_cnt++;
            m_ack = (ack_lat != 0) && (rq_cnt == ack_lat);
        end else begin
            rq_cnt = 0;
            m_ack  = idle_ack;
        end
    end

    // Transaction model: one transaction in flight, done the cycle after
    // completion, then one idle cycle before the next pick.
    bit            act = 1'b0;
    bit            resp = 1'b0;
    bit            side = 1'b0;   // 1 = data side
    bit            last = 1'b0;
    bit            mwe = 1'b0;
    logic [AW-1:0] maddr = '0;
    logic [BW-1:0] mwd = '0;
    logic [BW-1:0] e_ir = '0;
    logic [BW-1:0] e_dr = '0;
    bit            e_err = 1'b0;
    int            waited = 0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            act = 1'b0; resp = 1'b0; last = 1'b0;
            e_ir = '0; e_dr = '0; e_err = 1'b0; waited = 0;
        end else if (resp) begin
            resp = 1'b0;
        end else if (act) begin
            if (m_ack) begin
                if (!mwe) begin
                    if (side) e_dr = m_rdata;
                    else      e_ir = m_rdata;
                end
                act = 1'b0; resp = 1'b1;
            end else if (TO_EN && waited == int'(TO) - 1) begin
                act = 1'b0; resp = 1'b1; e_err = 1'b1;
            end else begin
                waited++;
            end
        end else if (i_req || d_req) begin
            side   = (i_req && d_req) ? ~last : d_req;
            last   = side;
            act    = 1'b1;
            waited = 0;
            maddr  = side ? d_addr : i_addr;
            mwe    = side & d_we;
            mwd    = d_wdata;
        end
    end

    always @(negedge CLK) begin
        chk1("cmp_busy", busy, act || resp);
        chk1("cmp_m_req", m_req, act);
        chk1("cmp_i_done", i_done, resp && !side);
        chk1("cmp_d_done", d_done, resp && side);
        chkw("cmp_i_rdata", i_rdata, e_ir);
        chkw("cmp_d_rdata", d_rdata, e_dr);
        chk1("cmp_err", err, e_err);
        if (act) begin
            chkw("cmp_m_addr", BW'(m_addr), BW'(maddr));
            chk1("cmp_m_we", m_we, mwe);
            if (mwe) chkw("cmp_m_wdata", m_wdata, mwd);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    logic [BW-1:0] lit;
    int            got;
    bit            order [4];

    initial begin
        RESET = 1'b1;
        #1 RESET = 1'b0;
        cyc(2);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_m_req", m_req, 1'b0);
        chk1("rst_m_we", m_we, 1'b0);
        chkw("rst_m_addr", BW'(m_addr), '0);
        chkw("rst_m_wdata", m_wdata, '0);
        chkw("rst_i_rdata", i_rdata, '0);
        chk1("rst_err", err, 1'b0);
        cyc(1);
        RESET = 1'b1;
        cyc(2);

        // I-side read alone, ack in first m_req cycle.
        ack_lat = 1;
        i_addr = 32'h100; i_req = 1'b1;
        cyc(1);
        chk1("t1_m_req", m_req, 1'b1);
        chk1("t1_m_we", m_we, 1'b0);
        chkw("t1_m_addr", BW'(m_addr), BW'(32'h100));
        cyc(1);
        chk1("t1_i_done", i_done, 1'b1);
        lit = {8{32'hC0DE_0100}};
        chkw("t1_i_rdata", i_rdata, lit);
        i_req = 1'b0;
        cyc(1);
        chk1("t1_idle_busy", busy, 1'b0);
        chk1("t1_done_gone", i_done, 1'b0);
        cyc(2);

        // D-side write, ack in fifth m_req cycle.
        ack_lat = 5;
        d_addr = 32'h200; d_we = 1'b1; d_wdata = {4{64'hDEAD_BEEF_0000_0001}};
        d_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            chk1("t2_m_req", m_req, 1'b1);
            chk1("t2_no_done", d_done, 1'b0);
            if (i == 1) begin
                chk1("t2_m_we", m_we, 1'b1);
                chkw("t2_m_addr", BW'(m_addr), BW'(32'h200));
                lit = {4{64'hDEAD_BEEF_0000_0001}};
                chkw("t2_m_wdata", m_wdata, lit);
            end
        end
        cyc(1);
        chk1("t2_d_done", d_done, 1'b1);
        chk1("t2_m_req_low", m_req, 1'b0);
        chkw("t2_d_rdata_kept", d_rdata, '0);
        d_req = 1'b0; d_we = 1'b0;
        cyc(1);
        chk1("t2_idle_busy", busy, 1'b0);
        cyc(2);

        // m_ack while idle must do nothing.
        idle_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk1("t5_busy", busy, 1'b0);
            chk1("t5_i_done", i_done, 1'b0);
            chk1("t5_d_done", d_done, 1'b0);
        end
        idle_ack = 1'b0;
        cyc(2);

        // Reset while D-side transaction is waiting on memory.
        ack_lat = 0;
        d_addr = 32'h500; d_we = 1'b0; d_req = 1'b1;
        cyc(3);
        chk1("t4_m_req_pre", m_req, 1'b1);
        chk1("t4_busy_pre", busy, 1'b1);
        #1 RESET = 1'b0;
        #1;
        chk1("t4_m_req_rst", m_req, 1'b0);
        chk1("t4_busy_rst", busy, 1'b0);
        chk1("t4_d_done_rst", d_done, 1'b0);
        d_req = 1'b0;
        cyc(2);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk1("t4_no_done", d_done, 1'b0);
            chk1("t4_idle", busy, 1'b0);
        end

        // Simultaneous requests after reset: D, I, D, I.
        ack_lat = 1;
        i_addr = 32'h300; d_addr = 32'h400; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            cyc(1);
            if (i_done || d_done) begin
                order[got] = d_done;
                if (got == 0) begin
                    lit = {8{32'hC0DE_0400}};
                    chkw("t3_d_rdata", d_rdata, lit);
                end
                if (got == 1) begin
                    lit = {8{32'hC0DE_0300}};
                    chkw("t3_i_rdata", i_rdata, lit);
                end
                got++;
                if (got == 4) begin
                    i_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk1("t3_all_done", got == 4, 1'b1);
        chk1("t3_first_d", order[0], 1'b1);
        chk1("t3_second_i", order[1], 1'b0);
        chk1("t3_third_d", order[2], 1'b1);
        chk1("t3_fourth_i", order[3], 1'b0);
        cyc(3);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: memory never acks.
        ack_lat = 0;
        i_addr = 32'h600; i_req = 1'b1;
        for (int i = 1; i <= int'(TO); i++) begin
            cyc(1);
            chk1("t6_m_req", m_req, 1'b1);
        end
        cyc(1);
        chk1("t6_m_req_drop", m_req, 1'b0);
        chk1("t6_i_done", i_done, 1'b1);
        chk1("t6_err", err, 1'b1);
        lit = {8{32'hC0DE_0300}};
        chkw("t6_i_rdata_kept", i_rdata, lit);
        i_req = 1'b0;
        cyc(3);
        chk1("t6_err_sticky", err, 1'b1);
        #1 RESET = 1'b0;
        #1;
        chk1("t6_err_cleared", err, 1'b0);
        cyc(1);
        RESET = 1'b1;
        cyc(2);
`else
        chk1("t6_err_tied", err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
